// File: rtl/serial_subtractor64_if.sv
// Operand/result handshake bundle for serial_subtractor64.
// The master drives operands and out_ready. The slave returns the result and flags.
interface serial_subtractor64_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] answer;
  logic             borrow_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, input1, input2, out_ready,
    input  in_ready, out_valid, answer, borrow_out, overflow, zero
  );

  modport slave (
    input  in_valid, input1, input2, out_ready,
    output in_ready, out_valid, answer, borrow_out, overflow, zero
  );
endinterface

// File: rtl/serial_subtractor64.sv
// Multi-cycle subtractor: answer = input1 - input2, processed CHUNK bits per cycle
// through a registered borrow, behind valid/ready handshakes on both sides.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | in_ready high; operands are latched when in_valid is high
// BUSY  | one CHUNK-wide slice per cycle, borrow carried in r_borrow
// DONE  | out_valid high; result and flags held until out_ready
module serial_subtractor64 #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_subtractor64_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
    $error("serial_subtractor64: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_in_ready;
  logic               w_out_valid;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [IDXW-1:0]    r_idx;
  logic               r_borrow;
  logic [WIDTH-1:0]   r_answer;
  logic               r_borrow_out;
  logic               r_overflow;
  logic               r_zero;

  logic [CHUNK-1:0]   w_a_chunk;
  logic [CHUNK-1:0]   w_b_chunk;
  logic [CHUNK:0]     w_diff;
  logic [WIDTH-1:0]   w_answer_next;
  logic               w_last;

  assign w_last = (r_idx == IDXW'(NCHUNK - 1));

  // Slice selection and write-back use constant part-selects under an index match.
  always_comb begin
    w_a_chunk     = '0;
    w_b_chunk     = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_idx == k[IDXW-1:0]) begin
        w_a_chunk = r_a[k*CHUNK +: CHUNK];
        w_b_chunk = r_b[k*CHUNK +: CHUNK];
      end
    end
    w_diff        = {1'b0, w_a_chunk} - {1'b0, w_b_chunk} - {{CHUNK{1'b0}}, r_borrow};
    w_answer_next = r_answer;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_idx == k[IDXW-1:0]) begin
        w_answer_next[k*CHUNK +: CHUNK] = w_diff[CHUNK-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_next = BUSY;
      end
      BUSY: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_idx        <= '0;
      r_borrow     <= 1'b0;
      r_answer     <= '0;
      r_borrow_out <= 1'b0;
      r_overflow   <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.in_valid) begin
        r_a      <= bus.input1;
        r_b      <= bus.input2;
        r_idx    <= '0;
        r_borrow <= 1'b0;
      end else if (r_state == BUSY) begin
        r_answer <= w_answer_next;
        r_borrow <= w_diff[CHUNK];
        r_idx    <= r_idx + 1'b1;
        // Flags see the fully assembled result, so they wait for the last slice.
        if (w_last) begin
          r_borrow_out <= w_diff[CHUNK];
          r_overflow   <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) &
                          (w_answer_next[WIDTH-1] ^ r_a[WIDTH-1]);
          r_zero       <= (w_answer_next == '0);
        end
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.answer     = r_answer;
  assign bus.borrow_out = r_borrow_out;
  assign bus.overflow   = r_overflow;
  assign bus.zero       = r_zero;
endmodule

// File: tb/tb_serial_subtractor64.sv
// Directed-vector bench for serial_subtractor64: arithmetic, flags, latency,
// backpressure, BUSY-time input isolation and mid-operation reset.
module tb_serial_subtractor64;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  serial_subtractor64_if #(.WIDTH(64)) bus ();

  serial_subtractor64 #(.WIDTH(64), .CHUNK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction with out_ready held high; checks latency, result, flags and return to IDLE.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_ans, input logic eb, input logic eo, input logic ez);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
    bus.input1   = a;
    bus.input2   = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk({tag, "_busy_rdy"}, {63'd0, bus.in_ready}, 64'd0);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) break;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd8);
    chk({tag, "_answer"}, bus.answer, exp_ans);
    chk({tag, "_flags"}, {61'd0, bus.borrow_out, bus.overflow, bus.zero}, {61'd0, eb, eo, ez});
    @(posedge clk);
    #1;
    chk({tag, "_release"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
  endtask

  initial begin
    int   n;
    logic seen;
    n_vec         = 0;
    n_miss        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.input1    = '0;
    bus.input2    = '0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    chk("reset_answer", bus.answer, 64'd0);
    chk("reset_flags", {61'd0, bus.borrow_out, bus.overflow, bus.zero}, 64'd0);
    rst_n = 1'b1;

    run_op("basic", 64'd100, 64'd58, 64'd42, 1'b0, 1'b0, 1'b0);
    run_op("wrap", 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("xchunk", 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0);
    run_op("equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 1'b0, 1'b1);
    run_op("ovf_neg", 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_op("noborrow", 64'h0123_4567_89AB_CDEF, 64'h0011_2233_4455_6677,
           64'h0112_2334_4556_6778, 1'b0, 1'b0, 1'b0);

    // Backpressure with operand changes and an in_valid pulse while BUSY.
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.input1   = 64'h1000;
    bus.input2   = 64'h0001;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.input1   = 64'd123;
    bus.input2   = 64'd77;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_answer", bus.answer, 64'h0FFF);
    chk("bp_flags", {61'd0, bus.borrow_out, bus.overflow, bus.zero}, 64'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold", {bus.out_valid, bus.in_ready, bus.answer[61:0]}, {2'b10, 62'h0FFF});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);

    run_op("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);

    // Abort in the fourth BUSY cycle; flags from the previous result must clear.
    @(negedge clk);
    bus.input1   = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.input2   = 64'd1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", {59'd0, bus.out_valid, bus.in_ready, bus.borrow_out, bus.overflow, bus.zero},
        64'b01000);
    chk("abort_answer", bus.answer, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    chk("abort_no_valid", {63'd0, seen}, 64'd0);

    run_op("after_abort", 64'd5, 64'd3, 64'd2, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
